// File: rtl/ball_engine_if.sv
// Frame handshake, speed/paddle inputs and pixel/status outputs of the ball engine.
// The slave modport is the engine side; the master modport is the game top side.
interface ball_engine_if;
    logic       go;
    logic [1:0] speed;
    logic [7:0] x_paddle_bot;
    logic [7:0] x_paddle_top;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       plot;
    logic       busy;
    logic       done;
    logic       miss_top;
    logic       miss_bot;
    logic [7:0] ball_x;
    logic [6:0] ball_y;

    modport master (
        output go, speed, x_paddle_bot, x_paddle_top,
        input  x_out, y_out, color_out, plot, busy, done,
        input  miss_top, miss_bot, ball_x, ball_y
    );

    modport slave (
        input  go, speed, x_paddle_bot, x_paddle_top,
        output x_out, y_out, color_out, plot, busy, done,
        output miss_top, miss_bot, ball_x, ball_y
    );
endinterface

// File: rtl/ball_engine.sv
// Ball controller: erases the sprite, waits, moves it with wall/paddle handling,
// redraws it one pixel per cycle and pulses done.
module ball_engine #(
    parameter int SPR_W     = 4,
    parameter int SPR_H     = 4,
    parameter int X_MIN     = 51,
    parameter int X_MAX     = 108,
    parameter int Y_TOP     = 12,
    parameter int Y_BOT     = 108,
    parameter int PAD_W     = 4,
    parameter int X_START   = 80,
    parameter int Y_START   = 60,
    parameter int MOVE_WAIT = 100000,
    parameter int MAX_STEP  = 3
) (
    input  logic           clk,
    input  logic           reset,
    ball_engine_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERASE = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int PW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int PH = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int WW = (MOVE_WAIT > 1) ? $clog2(MOVE_WAIT) : 1;

    localparam logic [PW-1:0] PX_LAST   = PW'(SPR_W - 1);
    localparam logic [PH-1:0] PY_LAST   = PH'(SPR_H - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MOVE_WAIT - 1);

    localparam logic [8:0] SW9     = 9'(SPR_W);
    localparam logic [8:0] SH9     = 9'(SPR_H);
    localparam logic [8:0] PADW9   = 9'(PAD_W);
    localparam logic [8:0] XMIN9   = 9'(X_MIN);
    localparam logic [8:0] XMAX9   = 9'(X_MAX);
    localparam logic [8:0] YTOP9   = 9'(Y_TOP);
    localparam logic [8:0] YBOT9   = 9'(Y_BOT);
    localparam logic [7:0] X_CLAMP = 8'(X_MAX - SPR_W + 1);
    localparam logic [6:0] Y_CLAMP = 7'(Y_BOT - SPR_H + 1);
    localparam logic [7:0] X_SERVE = 8'(X_START);
    localparam logic [6:0] Y_SERVE = 7'(Y_START);

    // Step 0 behaves as 1; anything past MAX_STEP saturates.
    function automatic logic [1:0] sat_step(input logic [1:0] s);
        logic [1:0] r;
        case (s)
            2'd0:    r = 2'd1;
            default: r = (32'(s) > MAX_STEP) ? 2'(MAX_STEP) : s;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        logic [2:0] r;
        case (c)
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5: r = c + 3'd1;
            default:                      r = 3'd1;
        endcase
        return r;
    endfunction

    // Inclusive column overlap of the sprite and a paddle, evaluated 9 bits wide.
    function automatic logic overlap(input logic [7:0] pad, input logic [7:0] bx);
        logic [8:0] p9;
        logic [8:0] b9;
        p9 = {1'b0, pad};
        b9 = {1'b0, bx};
        return (p9 <= b9 + SW9 - 9'd1) && (p9 + PADW9 - 9'd1 >= b9);
    endfunction

    logic [2:0]    state_r, state_s;
    logic [PW-1:0] px_r, px_s;
    logic [PH-1:0] py_r, py_s;
    logic [WW-1:0] wait_r, wait_s;
    logic [7:0]    bx_r, bx_s;
    logic [6:0]    by_r, by_s;
    logic          dx_r, dx_s;     // 0 = increasing column
    logic          dy_r, dy_s;     // 0 = moving down
    logic [2:0]    col_r, col_s;
    logic [1:0]    step_r, step_s;
    logic          miss_top_r, miss_top_s;
    logic          miss_bot_r, miss_bot_s;
    logic [7:0]    x_out_r, x_out_s;
    logic [6:0]    y_out_r, y_out_s;
    logic [2:0]    color_r, color_s;
    logic          plot_r, plot_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    logic [7:0]    ux_s;
    logic [6:0]    uy_s;
    logic          udx_s, udy_s, umt_s, umb_s;
    logic [8:0]    s9_s, bx9_s, by9_s;

    // Position/direction candidate for the end-of-move update.
    always_comb begin
        s9_s  = {7'd0, step_r};
        bx9_s = {1'b0, bx_r};
        by9_s = {2'b00, by_r};
        ux_s  = bx_r;
        uy_s  = by_r;
        udx_s = dx_r;
        udy_s = dy_r;
        umt_s = 1'b0;
        umb_s = 1'b0;
        if (!dx_r) begin
            if (bx9_s + s9_s + SW9 - 9'd1 >= XMAX9) begin
                ux_s  = X_CLAMP;
                udx_s = 1'b1;
            end else begin
                ux_s = bx_r + {6'd0, step_r};
            end
        end else begin
            if (bx9_s <= XMIN9 + s9_s) begin
                ux_s  = XMIN9[7:0];
                udx_s = 1'b0;
            end else begin
                ux_s = bx_r - {6'd0, step_r};
            end
        end
        if (!dy_r) begin
            if (by9_s + s9_s + SH9 - 9'd1 >= YBOT9) begin
                if (overlap(bus.x_paddle_bot, bx_r)) begin
                    uy_s  = Y_CLAMP;
                    udy_s = 1'b1;
                end else begin
                    // Re-serve wins over any wall clamp; dir_x keeps its old value.
                    umb_s = 1'b1;
                    ux_s  = X_SERVE;
                    uy_s  = Y_SERVE;
                    udx_s = dx_r;
                    udy_s = 1'b1;
                end
            end else begin
                uy_s = by_r + {5'd0, step_r};
            end
        end else begin
            if (by9_s <= YTOP9 + s9_s) begin
                if (overlap(bus.x_paddle_top, bx_r)) begin
                    uy_s  = YTOP9[6:0];
                    udy_s = 1'b0;
                end else begin
                    umt_s = 1'b1;
                    ux_s  = X_SERVE;
                    uy_s  = Y_SERVE;
                    udx_s = dx_r;
                    udy_s = 1'b0;
                end
            end else begin
                uy_s = by_r - {5'd0, step_r};
            end
        end
    end

    // Next-state and next-output computation; outputs are registered from these.
    always_comb begin
        state_s    = state_r;
        px_s       = px_r;
        py_s       = py_r;
        wait_s     = wait_r;
        bx_s       = bx_r;
        by_s       = by_r;
        dx_s       = dx_r;
        dy_s       = dy_r;
        col_s      = col_r;
        step_s     = step_r;
        miss_top_s = 1'b0;
        miss_bot_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.go) begin
                    state_s = S_ERASE;
                    px_s    = {PW{1'b0}};
                    py_s    = {PH{1'b0}};
                    step_s  = sat_step(bus.speed);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (px_r == PX_LAST && py_r == PY_LAST) begin
                    if (state_r == S_ERASE) begin
                        state_s = S_MOVE;
                        wait_s  = {WW{1'b0}};
                    end else begin
                        state_s = S_DONE;
                        col_s   = next_colour(col_r);
                    end
                end else if (px_r == PX_LAST) begin
                    px_s = {PW{1'b0}};
                    py_s = py_r + PH'(1);
                end else begin
                    px_s = px_r + PW'(1);
                end
            end
            S_MOVE: begin
                if (wait_r == WAIT_LAST) begin
                    state_s    = S_DRAW;
                    px_s       = {PW{1'b0}};
                    py_s       = {PH{1'b0}};
                    bx_s       = ux_s;
                    by_s       = uy_s;
                    dx_s       = udx_s;
                    dy_s       = udy_s;
                    miss_top_s = umt_s;
                    miss_bot_s = umb_s;
                end else begin
                    wait_s = wait_r + WW'(1);
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase

        plot_s = (state_s == S_ERASE) || (state_s == S_DRAW);
        if (plot_s) begin
            x_out_s = bx_s + 8'(px_s);
            y_out_s = by_s + 7'(py_s);
        end else begin
            x_out_s = 8'd0;
            y_out_s = 7'd0;
        end
        color_s = (state_s == S_DRAW) ? col_s : 3'd0;
        busy_s  = (state_s != S_IDLE);
        done_s  = (state_s == S_DONE);
    end

    // State and registered outputs; reset drops the frame and re-serves at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            px_r       <= {PW{1'b0}};
            py_r       <= {PH{1'b0}};
            wait_r     <= {WW{1'b0}};
            bx_r       <= X_SERVE;
            by_r       <= Y_SERVE;
            dx_r       <= 1'b0;
            dy_r       <= 1'b0;
            col_r      <= 3'd1;
            step_r     <= 2'd1;
            miss_top_r <= 1'b0;
            miss_bot_r <= 1'b0;
            x_out_r    <= 8'd0;
            y_out_r    <= 7'd0;
            color_r    <= 3'd0;
            plot_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            px_r       <= px_s;
            py_r       <= py_s;
            wait_r     <= wait_s;
            bx_r       <= bx_s;
            by_r       <= by_s;
            dx_r       <= dx_s;
            dy_r       <= dy_s;
            col_r      <= col_s;
            step_r     <= step_s;
            miss_top_r <= miss_top_s;
            miss_bot_r <= miss_bot_s;
            x_out_r    <= x_out_s;
            y_out_r    <= y_out_s;
            color_r    <= color_s;
            plot_r     <= plot_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign bus.x_out     = x_out_r;
    assign bus.y_out     = y_out_r;
    assign bus.color_out = color_r;
    assign bus.plot      = plot_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.miss_top  = miss_top_r;
    assign bus.miss_bot  = miss_bot_r;
    assign bus.ball_x    = bx_r;
    assign bus.ball_y    = by_r;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with a 4-cycle move wait; expected positions,
// colours and latencies are hand-computed from the serve point (80,60).
module tb_ball_engine;

    localparam int NPIX = 16;
    localparam int MW   = 4;
    localparam int LAT  = NPIX + MW + NPIX + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_engine_if bus ();

    ball_engine #(.MOVE_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int         r_lat, r_erase, r_draw, r_mb, r_mt, r_mb_cyc, r_walk_err;
    logic [2:0] r_dcol;
    logic [7:0] r_dx0;
    logic [6:0] r_dy0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: pulse go in IDLE, then sample every cycle on the falling edge until done.
    task automatic run_frame(input int spd, input int pb, input int pt, input bit walk,
                             input int ex, input int ey, input int dx, input int dy, input int dc);
        int  p;
        bit  ep;
        int  xe, ye, ce;
        @(negedge clk);
        bus.go = 1'b1;
        bus.speed = 2'(spd);
        bus.x_paddle_bot = 8'(pb);
        bus.x_paddle_top = 8'(pt);
        @(negedge clk);
        bus.go = 1'b0;
        r_lat = 0; r_erase = 0; r_draw = 0; r_mb = 0; r_mt = 0; r_mb_cyc = 0; r_walk_err = 0;
        r_dcol = 3'd0; r_dx0 = 8'd0; r_dy0 = 7'd0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.plot === 1'b1 && bus.color_out === 3'd0) r_erase++;
            if (bus.plot === 1'b1 && bus.color_out !== 3'd0) begin
                if (r_draw == 0) begin
                    r_dcol = bus.color_out;
                    r_dx0  = bus.x_out;
                    r_dy0  = bus.y_out;
                end
                r_draw++;
            end
            if (bus.miss_bot === 1'b1) begin
                r_mb++;
                r_mb_cyc = c;
            end
            if (bus.miss_top === 1'b1) r_mt++;
            if (walk) begin
                ep = 1'b0; xe = 0; ye = 0; ce = 0;
                if (c <= NPIX) begin
                    p = c - 1;  ep = 1'b1;
                    xe = ex + p % 4; ye = ey + p / 4; ce = 0;
                end else if (c > NPIX + MW && c <= NPIX + MW + NPIX) begin
                    p = c - NPIX - MW - 1;  ep = 1'b1;
                    xe = dx + p % 4; ye = dy + p / 4; ce = dc;
                end
                if (bus.plot !== ep || bus.busy !== 1'b1) r_walk_err++;
                else if (ep && (int'(bus.x_out) != xe || int'(bus.y_out) != ye ||
                                int'(bus.color_out) != ce)) r_walk_err++;
                if ((bus.done === 1'b1) != (c == LAT)) r_walk_err++;
            end
            if (bus.done === 1'b1) begin
                r_lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Replays the path from serve to (88,103) moving left and down.
    task automatic approach_bottom();
        run_frame(1, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        repeat (11) run_frame(2, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        repeat (2)  run_frame(3, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        repeat (7)  run_frame(2, 0, 0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int exp_col [7];
        exp_col = '{1, 2, 3, 4, 5, 6, 1};

        bus.go = 1'b0;
        bus.speed = 2'd0;
        bus.x_paddle_bot = 8'd0;
        bus.x_paddle_top = 8'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ball_x", bus.ball_x, 80);
        chk("rst_ball_y", bus.ball_y, 60);
        chk("rst_status", {bus.plot, bus.busy, bus.done, bus.miss_top, bus.miss_bot}, 0);
        chk("rst_pixel", {bus.x_out, bus.y_out, bus.color_out}, 0);
        reset = 1'b0;

        // First frame at speed 1: full pixel walk and latency.
        run_frame(1, 0, 0, 1'b1, 80, 60, 81, 61, 1);
        chk("first_walk", r_walk_err, 0);
        chk("first_latency", r_lat, LAT);
        chk("first_erase_cnt", r_erase, NPIX);
        chk("first_draw_cnt", r_draw, NPIX);
        chk("first_ball_x", bus.ball_x, 81);
        chk("first_ball_y", bus.ball_y, 61);
        @(negedge clk);
        chk("done_one_cycle", {bus.done, bus.busy}, 0);

        // Right wall at speed 3.
        repeat (11) run_frame(2, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("pre_wall_x", bus.ball_x, 103);
        chk("pre_wall_y", bus.ball_y, 83);
        run_frame(3, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("wall_clamp_x", bus.ball_x, 105);
        chk("wall_y", bus.ball_y, 86);
        run_frame(3, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("wall_rebound_x", bus.ball_x, 102);

        // Bottom paddle hit with single-column overlap.
        repeat (7) run_frame(2, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("pre_hit_xy", {bus.ball_x, 1'b0, bus.ball_y}, {8'd88, 1'b0, 7'd103});
        run_frame(2, 91, 0, 1'b1, 88, 103, 86, 105, 4);
        chk("hit_walk", r_walk_err, 0);
        chk("hit_ball_y", bus.ball_y, 105);
        chk("hit_no_miss", r_mb + r_mt, 0);
        run_frame(1, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("hit_dir_up_xy", {bus.ball_x, 1'b0, bus.ball_y}, {8'd85, 1'b0, 7'd104});

        // Bottom miss under the same conditions.
        do_reset();
        approach_bottom();
        chk("pre_miss_xy", {bus.ball_x, 1'b0, bus.ball_y}, {8'd88, 1'b0, 7'd103});
        run_frame(2, 0, 0, 1'b1, 88, 103, 80, 60, 4);
        chk("miss_walk", r_walk_err, 0);
        chk("miss_bot_pulses", r_mb, 1);
        chk("miss_bot_cycle", r_mb_cyc, NPIX + MW + 1);
        chk("miss_top_quiet", r_mt, 0);
        chk("miss_serve_xy", {bus.ball_x, 1'b0, bus.ball_y}, {8'd80, 1'b0, 7'd60});
        chk("miss_draw_row", r_dy0, 60);
        run_frame(1, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        chk("miss_dir_xy", {bus.ball_x, 1'b0, bus.ball_y}, {8'd79, 1'b0, 7'd59});

        // Colour sequence over seven frames.
        do_reset();
        for (int f = 0; f < 7; f++) begin
            run_frame(1, 0, 0, 1'b0, 0, 0, 0, 0, 0);
            chk($sformatf("colour_frame%0d", f + 1), r_dcol, exp_col[f]);
        end

        // Reset in the middle of the redraw.
        do_reset();
        @(negedge clk);
        bus.go = 1'b1;
        bus.speed = 2'd1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (27) @(negedge clk);
        chk("mid_draw_pixel", {bus.plot, bus.x_out, 1'b0, bus.y_out}, {1'b1, 8'd84, 1'b0, 7'd62});
        reset = 1'b1;
        #1;
        chk("mid_rst_plot_busy", {bus.plot, bus.busy}, 0);
        chk("mid_rst_ball", {bus.ball_x, 1'b0, bus.ball_y}, {8'd80, 1'b0, 7'd60});
        @(negedge clk);
        reset = 1'b0;
        run_frame(1, 0, 0, 1'b1, 80, 60, 81, 61, 1);
        chk("restart_walk", r_walk_err, 0);
        chk("restart_erase_cnt", r_erase, NPIX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Parametrised ball controller plus datapath: one FSM that erases the sprite, moves it, redraws it and reports done.
- Emits one pixel per cycle toward the VGA plot interface.
- Handles wall bounce, two-paddle collision, miss detection with re-serve, and runtime speed select.
- Sits between the game top-level frame scheduler (go/done handshake) and the shared VGA pixel mux.

Parameters:
- SPR_W, 4, sprite width in pixels (1..8).
- SPR_H, 4, sprite height in pixels (1..8).
- X_MIN, 51, left wall column.
- X_MAX, 108, right wall column; the sprite never crosses it.
- Y_TOP, 12, top paddle row; the sprite top edge bounces here.
- Y_BOT, 108, bottom paddle row; the sprite bottom edge bounces here.
- PAD_W, 4, paddle width in pixels.
- X_START, 80, serve column.
- Y_START, 60, serve row.
- MOVE_WAIT, 100000, idle cycles spent in MOVE before the position update (speed divider).
- MAX_STEP, 3, largest per-move step in pixels.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- go, in, 1, frame request; sampled only in IDLE.
- speed, in, 2, step size in pixels; 0 is treated as 1; values above MAX_STEP saturate to MAX_STEP; latched on leaving IDLE.
- x_paddle_bot, in, 8, left column of the bottom paddle.
- x_paddle_top, in, 8, left column of the top paddle.
- x_out, out, 8, pixel column.
- y_out, out, 7, pixel row.
- color_out, out, 3, pixel colour.
- plot, out, 1, pixel write strobe.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at frame end.
- miss_top, out, 1, one-cycle pulse when the ball passes the top paddle.
- miss_bot, out, 1, one-cycle pulse when the ball passes the bottom paddle.
- ball_x, out, 8, current top-left column.
- ball_y, out, 7, current top-left row.

Behaviour:
- Reset values:
  - State IDLE.
  - ball_x=X_START, ball_y=Y_START.
  - dir_x=+, dir_y=+.
  - colour register=1.
  - x_out=0, y_out=0, color_out=0.
  - plot, busy, done, miss_* all 0.
- FSM states: IDLE -> ERASE -> MOVE -> DRAW -> DONE -> IDLE.
  - IDLE: go=1 moves to ERASE on the next edge and latches the step.
- ERASE:
  - Pixel counter p runs 0..SPR_W*SPR_H-1, one per cycle, with plot=1 and color_out=0.
  - x_out=ball_x + p mod SPR_W; y_out=ball_y + p div SPR_W.
  - Exits to MOVE after the last pixel, so plot is high for exactly SPR_W*SPR_H cycles.
- MOVE:
  - plot=0; the wait counter runs MOVE_WAIT cycles.
  - On the final cycle, position and direction update once (rules below).
- DRAW:
  - Same pixel walk as ERASE, using the updated position and color_out=colour register.
  - On exit, the colour register advances 1..6 and wraps 6->1; 0 and 7 are never used.
- DONE: done=1 for one cycle, then IDLE. A go held high starts the next frame immediately.
- X update (step s):
  - Compute nx=ball_x ± s.
  - If moving + and nx+SPR_W-1 >= X_MAX: clamp to X_MAX-SPR_W+1 and set dir_x=-.
  - If moving - and nx <= X_MIN: clamp to X_MIN and set dir_x=+.
  - Compute all arithmetic 9 bits wide; no wrap is permitted.
- Y update, moving + (down):
  - The threshold is reached when ny+SPR_H-1 >= Y_BOT.
  - Hit: the sprite column range overlaps [x_paddle_bot, x_paddle_bot+PAD_W-1]. Clamp to Y_BOT-SPR_H+1 and set dir_y=-.
  - No hit: pulse miss_bot and re-serve (ball_x=X_START, ball_y=Y_START, dir_y=-). dir_x is unchanged.
- Y update, moving - (up):
  - Mirror of the down case against Y_TOP and x_paddle_top.
  - Hit clamps to Y_TOP; miss pulses miss_top and re-serves with dir_y=+.
- Overlap test uses 9-bit sums: a paddle touching exactly one sprite column counts as a hit.
- Simultaneous X and Y boundary in the same move: both resolve. A re-serve overrides the X clamp result.
- The miss pulse coincides with the position update cycle. done follows on the DONE cycle of the same frame.
- Paddle inputs are sampled only on the update cycle.
- Asynchronous reset mid-frame forces IDLE immediately, drops plot and busy, and restores the serve position. No partial erase is completed.
- go during a non-IDLE state is ignored; it is not queued.

Test Plan:
- Reset, then go with speed=1. Required:
  - 16 ERASE plots at (80..83, 60..63) with colour 0.
  - MOVE_WAIT idle cycles (MOVE_WAIT=4 in the bench).
  - 16 DRAW plots at (81..84, 61..64) with colour 1.
  - done pulse; total latency 16+4+16+1 cycles from go sampled.
- Right wall at speed 3: ball_x=103 moving + clamps to 105 with dir_x=- and no overshoot. Next frame gives ball_x=102.
- Bottom hit: ball_y=103 moving down, speed 2, x_paddle_bot=ball_x+3 (single-column overlap). Required: ball_y=105, dir_y=-, miss_bot stays 0.
- Bottom miss: x_paddle_bot=0 under the same conditions. Required:
  - miss_bot one-cycle pulse.
  - ball=(80,60), dir_y=-.
  - The subsequent DRAW plots at row 60.
- Colour wrap: run 7 frames. Required draw colours 1,2,3,4,5,6,1.
- Reset asserted during DRAW pixel 7. Required:
  - plot=0 and busy=0 within the same cycle.
  - ball=(80,60).
  - go then restarts a full 16-pixel ERASE.
